byte_stuffer_wide: RTL and testbench

BYTE_STUFFER_WIDE -- requirements
Module: byte_stuffer_wide

---
 rtl/byte_stuffer_wide.sv | 140 ++++++++++++++
 tb/tb_byte_stuffer_wide.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/byte_stuffer_wide.sv
// Wide-word byte stuffer: inserts 8'h00 after each 8'hFF, re-packs the byte
// stream into BYTES-wide words, and on flush drains and pads the final word.
module byte_stuffer_wide #(
  parameter int         BYTES = 2,
  parameter int         DEPTH = 4*BYTES,
  parameter logic [7:0] PAD   = 8'h00
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ena_in,
  output logic               rdy_out,
  input  logic [8*BYTES-1:0] in,
  output logic               ena_out,
  input  logic               rdy_in,
  output logic [8*BYTES-1:0] out,
  input  logic               stuff_en,
  input  logic               flush,
  output logic               done,
  output logic [15:0]        stuff_cnt
);

  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW   = $clog2(DEPTH+1);
  localparam int WMAX = 2*BYTES;

  typedef enum logic [1:0] {S_RUN, S_DRAIN, S_PAD, S_DONE} state_t;

  state_t            state, state_nx;
  logic [7:0]        mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     cnt;

  logic [7:0]        wb [WMAX];
  logic [7:0]        ib;
  int                wr_n, ins_n, rd_n;
  logic [8*BYTES-1:0] rw, pw;
  logic              acc, out_free, ld_full, ld_pad;
  logic [16:0]       sc_sum;

  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PW'(s);
  endfunction

  // Expand the accepted word into up to 2*BYTES stream bytes, MSB first.
  always_comb begin
    wr_n  = 0;
    ins_n = 0;
    ib    = '0;
    for (int k = 0; k < WMAX; k++) wb[k] = '0;
    for (int i = 0; i < BYTES; i++) begin
      ib = in[8*(BYTES-1-i) +: 8];
      wb[wr_n] = ib;
      wr_n++;
      if (stuff_en && ib == 8'hFF) begin
        wb[wr_n] = 8'h00;
        wr_n++;
        ins_n++;
      end
    end
  end

  // Oldest BYTES bytes as a full word, and the short tail padded with PAD.
  always_comb begin
    rw = '0;
    pw = '0;
    for (int j = 0; j < BYTES; j++) begin
      rw[8*(BYTES-1-j) +: 8] = mem[wrap(rd_ptr, j)];
      pw[8*(BYTES-1-j) +: 8] = (j < int'(cnt)) ? mem[wrap(rd_ptr, j)] : PAD;
    end
  end

  always_comb begin
    rdy_out  = (state == S_RUN) && !flush && (int'(cnt) <= DEPTH - WMAX);
    acc      = ena_in && rdy_out;
    out_free = !ena_out || rdy_in;
    ld_full  = (state == S_RUN || state == S_DRAIN) && (int'(cnt) >= BYTES) && out_free;
    ld_pad   = (state == S_PAD) && !ena_out;
    rd_n     = 0;
    if (ld_full)     rd_n = BYTES;
    else if (ld_pad) rd_n = int'(cnt);
    done     = (state == S_DONE);
    sc_sum   = {1'b0, stuff_cnt} + 17'(ins_n);
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN, S_DRAIN: begin
        if (flush || state == S_DRAIN) begin
          // Only a short tail with an idle output register ends the drain.
          if (int'(cnt) < BYTES && !ena_out) state_nx = (cnt == '0) ? S_DONE : S_PAD;
          else                               state_nx = S_DRAIN;
        end
      end
      S_PAD:   if (ena_out && rdy_in) state_nx = S_DONE;
      S_DONE:  if (!flush) state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cnt       <= '0;
      ena_out   <= 1'b0;
      out       <= '0;
      stuff_cnt <= '0;
    end else begin
      state <= state_nx;
      if (acc) begin
        wr_ptr    <= wrap(wr_ptr, wr_n);
        stuff_cnt <= sc_sum[16] ? 16'hFFFF : sc_sum[15:0];
      end
      if (ld_full || ld_pad) rd_ptr <= wrap(rd_ptr, rd_n);
      cnt <= CW'(int'(cnt) + (acc ? wr_n : 0) - rd_n);
      if (ld_full) begin
        out     <= rw;
        ena_out <= 1'b1;
      end else if (ld_pad) begin
        out     <= pw;
        ena_out <= 1'b1;
      end else if (rdy_in) begin
        ena_out <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && acc) begin
      for (int k = 0; k < WMAX; k++)
        if (k < wr_n) mem[wrap(wr_ptr, k)] <= wb[k];
    end
  end

endmodule

// File: tb/tb_byte_stuffer_wide.sv
// Bench for byte_stuffer_wide: table vectors, hand-written corner sequences and
// randomized traffic scored against a byte-queue reference model.
module tb_byte_stuffer_wide;
  localparam int         B    = 2;
  localparam logic [7:0] PADB = 8'h00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, ena_in, rdy_in, stuff_en, flush;
  logic [15:0] in_w;
  logic        rdy_out, ena_out, done;
  logic [15:0] out_w, stuff_cnt;

  logic        ena4, rdy4, st4, fl4;
  logic [31:0] in4;
  logic        rdy4o, ena4o, done4;
  logic [31:0] out4;
  logic [15:0] stuff_cnt4;

  byte_stuffer_wide #(.BYTES(B)) u_dut (
    .clk(clk), .rst(rst), .ena_in(ena_in), .rdy_out(rdy_out), .in(in_w),
    .ena_out(ena_out), .rdy_in(rdy_in), .out(out_w), .stuff_en(stuff_en),
    .flush(flush), .done(done), .stuff_cnt(stuff_cnt));

  byte_stuffer_wide #(.BYTES(4)) u_dut4 (
    .clk(clk), .rst(rst), .ena_in(ena4), .rdy_out(rdy4o), .in(in4),
    .ena_out(ena4o), .rdy_in(rdy4), .out(out4), .stuff_en(st4),
    .flush(fl4), .done(done4), .stuff_cnt(stuff_cnt4));

  int          checks = 0, failures = 0;
  logic [7:0]  mq[$];
  logic [15:0] cap[$];
  int          exp_stuff;
  logic        acc, hold_pend;
  logic [15:0] hold_out;

  typedef struct {
    logic [15:0] win;
    logic [15:0] exp_on;
    logic [15:0] exp_off;
  } row_t;
  row_t tab [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Called with inputs stable, away from the clock edge; scores the handshakes
  // that the coming rising edge will complete.
  task automatic sample();
    logic [15:0] e;
    logic [7:0]  b;
    if (hold_pend) begin
      chk("hold_out", {16'h0, out_w}, {16'h0, hold_out});
      chk("hold_ena", {31'h0, ena_out}, 32'h1);
    end
    hold_pend = ena_out && !rdy_in;
    hold_out  = out_w;
    if (ena_out && rdy_in) begin
      cap.push_back(out_w);
      e = '0;
      if (mq.size() >= B) begin
        for (int i = 0; i < B; i++) e = {e[7:0], mq.pop_front()};
        chk("word", {16'h0, out_w}, {16'h0, e});
      end else if (mq.size() > 0 && flush) begin
        for (int i = 0; i < B; i++) e = {e[7:0], (mq.size() > 0) ? mq.pop_front() : PADB};
        chk("pad_word", {16'h0, out_w}, {16'h0, e});
      end else begin
        checks++;
        failures++;
        $display("FAIL unexpected_word actual=%h required=none", out_w);
      end
    end
    acc = ena_in && rdy_out;
    if (acc) begin
      for (int i = 0; i < B; i++) begin
        b = in_w[8*(B-1-i) +: 8];
        mq.push_back(b);
        if (stuff_en && b == 8'hFF) begin
          mq.push_back(8'h00);
          exp_stuff++;
        end
      end
    end
  endtask

  task automatic tick();
    #1;
    sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; ena_in = 1'b0; flush = 1'b0; rdy_in = 1'b1; stuff_en = 1'b0; in_w = '0;
    ena4 = 1'b0; rdy4 = 1'b1; st4 = 1'b0; fl4 = 1'b0; in4 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    cap.delete();
    exp_stuff = 0;
    hold_pend = 1'b0;
  endtask

  task automatic run_until_done(input int bound);
    int n;
    for (n = 0; n < bound; n++) begin
      #1;
      if (done) break;
      sample();
      @(negedge clk);
    end
    chk("done_reached", {31'h0, done}, 32'h1);
    chk("model_empty", mq.size(), 0);
    chk("stuff_cnt_model", {16'h0, stuff_cnt}, exp_stuff);
  endtask

  task automatic finish_flush();
    flush = 1'b0;
    tick();
    #1;
    chk("done_fall", {31'h0, done}, 32'h0);
    chk("rdy_after_done", {31'h0, rdy_out}, 32'h1);
  endtask

  task automatic run_table(input logic s);
    int idx, nexp;
    idx = 0;
    cap.delete();
    stuff_en = s;
    rdy_in = 1'b1;
    for (int n = 0; n < 40 && idx < 5; n++) begin
      ena_in = 1'b1;
      in_w = tab[idx].win;
      #1;
      sample();
      if (acc) idx++;
      @(negedge clk);
    end
    ena_in = 1'b0;
    flush = 1'b1;
    run_until_done(40);
    nexp = s ? 7 : 5;
    chk(s ? "tab_len_on" : "tab_len_off", cap.size(), nexp);
    for (int i = 0; i < nexp; i++)
      chk(s ? "tab_on" : "tab_off", {16'h0, (i < cap.size()) ? cap[i] : 16'hxxxx},
          {16'h0, s ? tab[i].exp_on : tab[i].exp_off});
    chk("tab_stuff_cnt", {16'h0, stuff_cnt}, s ? 32'd3 : 32'd0);
    finish_flush();
  endtask

  task automatic run_random(input int ncyc, input int ff_pct);
    logic [7:0] b0, b1;
    for (int n = 0; n < ncyc; n++) begin
      b0 = ($urandom_range(99) < ff_pct) ? 8'hFF : 8'($urandom);
      b1 = ($urandom_range(99) < ff_pct) ? 8'hFF : 8'($urandom);
      ena_in   = ($urandom_range(3) != 0);
      in_w     = {b0, b1};
      stuff_en = $urandom_range(1) != 0;
      rdy_in   = ($urandom_range(9) < 7);
      tick();
    end
    ena_in = 1'b0;
    rdy_in = 1'b1;
    flush  = 1'b1;
    run_until_done(100);
    finish_flush();
  endtask

  initial begin
    int k, acc4;
    logic found;
    logic [31:0] c4[$];

    tab[0] = '{16'h1234, 16'h1234, 16'h1234};
    tab[1] = '{16'hFFAB, 16'hFF00, 16'hFFAB};
    tab[2] = '{16'h1234, 16'hAB12, 16'h1234};
    tab[3] = '{16'hFF56, 16'h34FF, 16'hFF56};
    tab[4] = '{16'hABFF, 16'h0056, 16'hABFF};
    tab[5] = '{16'h0000, 16'hABFF, 16'h0000};
    tab[6] = '{16'h0000, 16'h0000, 16'h0000};

    do_reset();
    #1;
    chk("rst_ena_out", {31'h0, ena_out}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_stuff_cnt", {16'h0, stuff_cnt}, 32'h0);
    chk("rst_out", {16'h0, out_w}, 32'h0);
    chk("rst_rdy_out", {31'h0, rdy_out}, 32'h1);

    // Flush of an empty block.
    flush = 1'b1;
    #1;
    chk("eflush_rdy_low", {31'h0, rdy_out}, 32'h0);
    @(negedge clk);
    #1;
    chk("eflush_done", {31'h0, done}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("eflush_no_word", {31'h0, ena_out}, 32'h0);
      @(negedge clk);
    end
    finish_flush();

    do_reset();
    run_table(1'b1);
    do_reset();
    run_table(1'b0);

    // Downstream stall: output held, input backs up, nothing lost.
    do_reset();
    stuff_en = 1'b0;
    rdy_in = 1'b0;
    k = 1;
    for (int n = 0; n < 8; n++) begin
      ena_in = 1'b1;
      in_w = 16'h0101 * k[15:0];
      #1;
      sample();
      if (acc) k++;
      @(negedge clk);
    end
    #1;
    chk("stall_accepted", k - 1, 4);
    chk("stall_rdy_low", {31'h0, rdy_out}, 32'h0);
    chk("stall_out", {16'h0, out_w}, 32'h0101);
    ena_in = 1'b0;
    rdy_in = 1'b1;
    flush = 1'b1;
    cap.delete();
    run_until_done(40);
    chk("stall_words_out", cap.size(), 4);
    finish_flush();

    // Reset while the padded final word is waiting in the output register.
    do_reset();
    stuff_en = 1'b1;
    rdy_in = 1'b1;
    ena_in = 1'b1;
    in_w = 16'hFF12;
    tick();
    ena_in = 1'b0;
    flush = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (ena_out && out_w == 16'h1200) begin
        found = 1'b1;
        break;
      end
      sample();
      @(negedge clk);
    end
    chk("pad_reached", {31'h0, found}, 32'h1);
    rdy_in = 1'b0;
    rst = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    exp_stuff = 0;
    hold_pend = 1'b0;
    #1;
    chk("padrst_ena_out", {31'h0, ena_out}, 32'h0);
    chk("padrst_done", {31'h0, done}, 32'h0);
    chk("padrst_stuff_cnt", {16'h0, stuff_cnt}, 32'h0);
    chk("padrst_run", {31'h0, rdy_out}, 32'h1);
    rdy_in = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      #1;
      chk("padrst_no_word", {31'h0, ena_out}, 32'h0);
    end

    // Four-byte instance: all-FF word doubles into two stuffed words.
    do_reset();
    ena4 = 1'b1; in4 = 32'hFFFFFFFF; st4 = 1'b1; rdy4 = 1'b0;
    acc4 = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (i == 1) chk("w4_stuff_one", {16'h0, stuff_cnt4}, 32'd4);
      if (ena4 && rdy4o) acc4++;
      @(negedge clk);
    end
    #1;
    chk("w4_accepted", acc4, 2);
    chk("w4_rdy_low", {31'h0, rdy4o}, 32'h0);
    chk("w4_held", out4, 32'hFF00FF00);
    ena4 = 1'b0;
    rdy4 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (ena4o && rdy4) c4.push_back(out4);
      @(negedge clk);
    end
    #1;
    chk("w4_words", c4.size(), 4);
    foreach (c4[i]) chk("w4_word", c4[i], 32'hFF00FF00);
    chk("w4_stuff_cnt", {16'h0, stuff_cnt4}, 32'd8);
    chk("w4_rdy_back", {31'h0, rdy4o}, 32'h1);

    do_reset();
    run_random(400, 30);
    do_reset();
    run_random(400, 70);
    do_reset();
    run_random(300, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
